// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: captures decoded instructions, forwards operands and presents
// registered operands to the ALU through a 2-entry skid buffer. Forwarding network is
// compiled in only when BUTTERFLY_FWD_EN is defined.
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_rd_we_i,
  input  logic [ALU_OP_W-1:0]   id_alu_op_i,
  input  logic                  id_op_a_sel_i,
  input  logic                  id_op_b_sel_i,
  input  logic                  fwd_exmem_we_i,
  input  logic [REG_ADDR_W-1:0] fwd_exmem_rd_i,
  input  logic [XLEN-1:0]       fwd_exmem_data_i,
  input  logic                  fwd_memwb_we_i,
  input  logic [REG_ADDR_W-1:0] fwd_memwb_rd_i,
  input  logic [XLEN-1:0]       fwd_memwb_data_i,
  output logic                  ex_valid_o,
  input  logic                  ex_ready_i,
  output logic [XLEN-1:0]       ex_operand_a_o,
  output logic [XLEN-1:0]       ex_operand_b_o,
  output logic [ALU_OP_W-1:0]   ex_alu_op_o,
  output logic [XLEN-1:0]       ex_rs2_data_o,
  output logic [XLEN-1:0]       ex_pc_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_rd_we_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       rs2;
    logic [XLEN-1:0]       pc;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_we;
  } entry_t;

  state_t          state;
  entry_t          main_q;
  entry_t          skid_q;
  entry_t          in_entry;
  logic            accept;
  logic            consume;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Handshake: valid never waits on ready, ready never depends on ex_ready_i.
  // Accept = id_valid_i & id_ready_o; consume = ex_valid_o & ex_ready_i.
  assign id_ready_o  = (state != S_TWO);
  assign ex_valid_o  = (state != S_EMPTY);
  assign accept      = id_valid_i & id_ready_o;
  assign consume     = ex_valid_o & ex_ready_i;
  assign dbg_state_o = state;

`ifdef BUTTERFLY_FWD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB; x0 is hardwired zero.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       rf_data,
    input logic                  exmem_we,
    input logic [REG_ADDR_W-1:0] exmem_rd,
    input logic [XLEN-1:0]       exmem_data,
    input logic                  memwb_we,
    input logic [REG_ADDR_W-1:0] memwb_rd,
    input logic [XLEN-1:0]       memwb_data
  );
    logic [XLEN-1:0] res;
    res = rf_data;
    if (addr != '0) begin
      if (exmem_we && (exmem_rd == addr)) begin
        res = exmem_data;
      end else if (memwb_we && (memwb_rd == addr)) begin
        res = memwb_data;
      end
    end
    return res;
  endfunction

  always_comb begin
    fwd_rs1 = fwd_pick(id_rs1_addr_i, id_rs1_data_i,
                       fwd_exmem_we_i, fwd_exmem_rd_i, fwd_exmem_data_i,
                       fwd_memwb_we_i, fwd_memwb_rd_i, fwd_memwb_data_i);
    fwd_rs2 = fwd_pick(id_rs2_addr_i, id_rs2_data_i,
                       fwd_exmem_we_i, fwd_exmem_rd_i, fwd_exmem_data_i,
                       fwd_memwb_we_i, fwd_memwb_rd_i, fwd_memwb_data_i);
  end
`else
  // Hazards are stalled upstream; bypass inputs and register indices are not needed.
  logic unused_fwd;
  assign unused_fwd = ^{fwd_exmem_we_i, fwd_exmem_rd_i, fwd_exmem_data_i,
                        fwd_memwb_we_i, fwd_memwb_rd_i, fwd_memwb_data_i,
                        id_rs1_addr_i, id_rs2_addr_i};

  always_comb begin
    fwd_rs1 = id_rs1_data_i;
    fwd_rs2 = id_rs2_data_i;
  end
`endif

  always_comb begin
    in_entry        = '0;
    in_entry.op_a   = id_op_a_sel_i ? id_pc_i  : fwd_rs1;
    in_entry.op_b   = id_op_b_sel_i ? id_imm_i : fwd_rs2;
    in_entry.rs2    = fwd_rs2;
    in_entry.pc     = id_pc_i;
    in_entry.alu_op = id_alu_op_i;
    in_entry.rd     = id_rd_addr_i;
    in_entry.rd_we  = id_rd_we_i;
  end

  // Main register drives EX; skid only fills when main is held and a new one arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            main_q <= in_entry;
            state  <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_q <= in_entry;
            state  <= S_TWO;
          end else if (consume) begin
            state <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (consume) begin
            main_q <= skid_q;
            state  <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign ex_operand_a_o = main_q.op_a;
  assign ex_operand_b_o = main_q.op_b;
  assign ex_alu_op_o    = main_q.alu_op;
  assign ex_rs2_data_o  = main_q.rs2;
  assign ex_pc_o        = main_q.pc;
  assign ex_rd_addr_o   = main_q.rd;
  assign ex_rd_we_o     = main_q.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: scoreboard of expected issues plus directed scenario tasks.
// Expectations follow BUTTERFLY_FWD_EN the same way the build does.
module tb_alu_issue_stage;

  localparam int W = 32 * 4 + 4 + 5 + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic        id_rd_we = 1'b0;
  logic [3:0]  id_alu_op = '0;
  logic        id_op_a_sel = 1'b0, id_op_b_sel = 1'b0;
  logic        fwd_exmem_we = 1'b0, fwd_memwb_we = 1'b0;
  logic [4:0]  fwd_exmem_rd = '0, fwd_memwb_rd = '0;
  logic [31:0] fwd_exmem_data = '0, fwd_memwb_data = '0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [31:0] ex_operand_a, ex_operand_b, ex_rs2_data, ex_pc;
  logic [3:0]  ex_alu_op;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int issued = 0;
  bit rand_ready = 1'b0;

  alu_issue_stage dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
    .id_rd_addr_i(id_rd_addr), .id_rd_we_i(id_rd_we), .id_alu_op_i(id_alu_op),
    .id_op_a_sel_i(id_op_a_sel), .id_op_b_sel_i(id_op_b_sel),
    .fwd_exmem_we_i(fwd_exmem_we), .fwd_exmem_rd_i(fwd_exmem_rd),
    .fwd_exmem_data_i(fwd_exmem_data), .fwd_memwb_we_i(fwd_memwb_we),
    .fwd_memwb_rd_i(fwd_memwb_rd), .fwd_memwb_data_i(fwd_memwb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_operand_a_o(ex_operand_a), .ex_operand_b_o(ex_operand_b),
    .ex_alu_op_o(ex_alu_op), .ex_rs2_data_o(ex_rs2_data), .ex_pc_o(ex_pc),
    .ex_rd_addr_o(ex_rd_addr), .ex_rd_we_o(ex_rd_we), .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_fwd(input logic [4:0] rs, input logic [31:0] rf);
`ifdef BUTTERFLY_FWD_EN
    if (rs != 5'd0 && fwd_exmem_we && fwd_exmem_rd == rs) return fwd_exmem_data;
    if (rs != 5'd0 && fwd_memwb_we && fwd_memwb_rd == rs) return fwd_memwb_data;
`endif
    return rf;
  endfunction

  function automatic logic [W-1:0] model_entry();
    logic [31:0] r1, r2, a, b;
    r1 = model_fwd(id_rs1_addr, id_rs1_data);
    r2 = model_fwd(id_rs2_addr, id_rs2_data);
    a  = id_op_a_sel ? id_pc : r1;
    b  = id_op_b_sel ? id_imm : r2;
    return {a, b, id_alu_op, r2, id_pc, id_rd_addr, id_rd_we};
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!rst && ex_valid && ex_ready) begin
      got = {ex_operand_a, ex_operand_b, ex_alu_op, ex_rs2_data, ex_pc, ex_rd_addr, ex_rd_we};
      checks++;
      issued++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got %h, required no issue", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL issue_data: got %h, required %h", got, exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic set_insn(input logic [31:0] pc, input logic [31:0] rs1d, input logic [31:0] rs2d,
                          input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [3:0] op, input logic sa, input logic sb);
    id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd; id_rd_we = (rd != 5'd0);
    id_alu_op = op; id_op_a_sel = sa; id_op_b_sel = sb;
  endtask

  // Offers the staged instruction until accepted; returns #1 after the accepting edge.
  task automatic send(output int waits);
    bit accepted;
    accepted = 1'b0;
    waits = 0;
    id_valid = 1'b1;
    while (!accepted && waits < 50) begin
      if (rand_ready) ex_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (id_ready) begin
        exp_q.push_back(model_entry());
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (!accepted) waits++;
    end
    id_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL send_timeout: id_ready stayed 0 for %0d cycles, required accept", waits);
    end
  endtask

  task automatic send_rand(output int waits);
    set_insn($urandom, $urandom, $urandom, $urandom, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    send(waits);
  endtask

  task automatic drain();
    int n;
    ex_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries never issued, required 0", exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({ex_valid, ex_operand_a, ex_operand_b, ex_alu_op, ex_rs2_data, ex_pc, ex_rd_addr, ex_rd_we} !== '0
        || id_ready !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s: valid=%b a=%h b=%h pc=%h ready=%b state=%0d, required all ex_* 0, ready=1, state=0",
               name, ex_valid, ex_operand_a, ex_operand_b, ex_pc, id_ready, dbg_state);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int w;
    ex_ready = 1'b1;
    set_insn(32'h100, 32'h10, 32'h77, 32'h5, 5'd1, 5'd2, 5'd3, 4'd0, 1'b0, 1'b1);
    send(w);
    checks++;
    if (ex_valid !== 1'b1 || ex_operand_a !== 32'h10 || ex_operand_b !== 32'h5) begin
      errors++;
      $display("FAIL basic_add: valid=%b a=%h b=%h, required 1 00000010 00000005",
               ex_valid, ex_operand_a, ex_operand_b);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    ex_ready = 1'b0;
    set_insn(32'h200, 32'h1111, 32'h2222, 32'h0, 5'd1, 5'd2, 5'd4, 4'd1, 1'b0, 1'b0);
    send(w);
    set_insn(32'h204, 32'h3333, 32'h4444, 32'h8, 5'd1, 5'd2, 5'd5, 4'd2, 1'b1, 1'b1);
    send(w);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (id_ready !== 1'b0 || dbg_state !== 2'd2 || ex_operand_a !== 32'h1111 || ex_pc !== 32'h200) begin
      errors++;
      $display("FAIL b2b_hold: ready=%b state=%0d a=%h pc=%h, required 0 2 00001111 00000200",
               id_ready, dbg_state, ex_operand_a, ex_pc);
    end
    ex_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (id_ready !== 1'b1 || ex_valid !== 1'b1 || ex_operand_a !== 32'h204 || ex_operand_b !== 32'h8) begin
      errors++;
      $display("FAIL b2b_second: ready=%b valid=%b a=%h b=%h, required 1 1 00000204 00000008",
               id_ready, ex_valid, ex_operand_a, ex_operand_b);
    end
    drain();
  endtask

  task automatic test_forwarding();
    int w;
    logic [31:0] exp_a;
    ex_ready = 1'b1;
    fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd5; fwd_exmem_data = 32'hAA;
    fwd_memwb_we = 1'b1; fwd_memwb_rd = 5'd5; fwd_memwb_data = 32'hBB;
    set_insn(32'h300, 32'h11, 32'h22, 32'h4, 5'd5, 5'd5, 5'd6, 4'd3, 1'b0, 1'b0);
`ifdef BUTTERFLY_FWD_EN
    exp_a = 32'hAA;
`else
    exp_a = 32'h11;
`endif
    send(w);
    checks++;
    if (ex_operand_a !== exp_a) begin
      errors++;
      $display("FAIL fwd_exmem_prio: a=%h, required %h", ex_operand_a, exp_a);
    end
    fwd_exmem_we = 1'b0;
`ifdef BUTTERFLY_FWD_EN
    exp_a = 32'hBB;
`else
    exp_a = 32'h11;
`endif
    send(w);
    checks++;
    if (ex_operand_a !== exp_a) begin
      errors++;
      $display("FAIL fwd_memwb: a=%h, required %h", ex_operand_a, exp_a);
    end
    fwd_exmem_we = 1'b1; fwd_exmem_rd = 5'd0; fwd_memwb_rd = 5'd0;
    set_insn(32'h308, 32'h33, 32'h44, 32'h4, 5'd0, 5'd0, 5'd6, 4'd3, 1'b0, 1'b0);
    send(w);
    checks++;
    if (ex_operand_a !== 32'h33 || ex_rs2_data !== 32'h44) begin
      errors++;
      $display("FAIL fwd_x0: a=%h rs2=%h, required 00000033 00000044", ex_operand_a, ex_rs2_data);
    end
    drain();
    fwd_exmem_we = 1'b0; fwd_memwb_we = 1'b0;
  endtask

  task automatic test_flush();
    int w;
    ex_ready = 1'b0;
    set_insn(32'h400, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd7, 4'd4, 1'b0, 1'b1);
    send(w);
    set_insn(32'h404, 32'h4, 32'h5, 32'h6, 5'd1, 5'd2, 5'd8, 4'd4, 1'b0, 1'b1);
    send(w);
    set_insn(32'h408, 32'h7, 32'h8, 32'h9, 5'd1, 5'd2, 5'd9, 4'd4, 1'b0, 1'b1);
    id_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    id_valid = 1'b0;
    exp_q.delete();
    checks++;
    if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: valid=%b ready=%b, required 0 1", ex_valid, id_ready);
    end
    ex_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ex_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_issue: valid=%b at cycle %0d, required 0", ex_valid, i);
      end
    end
  endtask

  task automatic test_stream();
    int w, stalls, base;
    ex_ready = 1'b1;
    stalls = 0;
    base = issued;
    for (int i = 0; i < 8; i++) begin
      send_rand(w);
      stalls += w;
      checks++;
      if (ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid: valid=%b at insn %0d, required 1", ex_valid, i);
      end
    end
    drain();
    checks++;
    if (stalls != 0 || issued - base != 8) begin
      errors++;
      $display("FAIL stream_throughput: stalls=%0d issued=%0d, required 0 8", stalls, issued - base);
    end
  endtask

  task automatic test_random();
    int w;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fwd_exmem_we = 1'($urandom_range(0, 1)); fwd_exmem_rd = 5'($urandom_range(0, 3));
      fwd_exmem_data = $urandom;
      fwd_memwb_we = 1'($urandom_range(0, 1)); fwd_memwb_rd = 5'($urandom_range(0, 3));
      fwd_memwb_data = $urandom;
      send_rand(w);
    end
    rand_ready = 1'b0;
    drain();
  endtask

  task automatic test_reset_in_one();
    int w;
    ex_ready = 1'b0;
    set_insn(32'h500, 32'hDEAD, 32'hBEEF, 32'h1, 5'd1, 5'd2, 5'd10, 4'd5, 1'b0, 1'b0);
    send(w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("reset_in_one");
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_back_to_back();
    test_forwarding();
    test_flush();
    test_stream();
    test_random();
    test_reset_in_one();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
